// File: rtl/bram_pkg.sv
// bram_pkg: shared state encoding, default sizes and address-width helper for the bram port path
package bram_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_e;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_MAX_BURST = 16;
  function automatic int addr_w(input int num_bits);
    return num_bits + 8;
  endfunction
endpackage

// File: rtl/bram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick, rr_ptr breaks ties
module rr_arbiter2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       rr_ptr,
  output logic [1:0] winner
);
  assign winner = (req0 & req1) ? (rr_ptr ? 2'b10 : 2'b01) : {req1, req0};
endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares the bram port between the uart controller and the fill/scrub engine
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int NUM_BLOCKS = 16,
  parameter int NUM_BITS   = $clog2(NUM_BLOCKS),
  parameter int ADDR_W     = addr_w(NUM_BITS),
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              last0,
  input  logic              last1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  state_e           state_q;
  logic             rr_ptr_q;
  logic [CNT_W-1:0] burst_cnt_q;
  logic             rvalid0_q, rvalid1_q;
  logic             own0, own1, gnt, we_sel, release_now;
  logic [1:0]       winner;
  rr_arbiter2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .rr_ptr(rr_ptr_q),
    .winner(winner)
  );
  // Owner-selected port mux; an owner that drops req issues nothing
  always_comb begin
    own0        = state_q == OWN0;
    own1        = state_q == OWN1;
    gnt0        = own0 & req0;
    gnt1        = own1 & req1;
    gnt         = gnt0 | gnt1;
    we_sel      = own0 ? we0 : we1;
    mem_rd_en   = gnt & ~we_sel;
    mem_wr_en   = gnt & we_sel;
    mem_addr    = own0 ? addr0 : own1 ? addr1 : '0;
    mem_wdata   = own0 ? wdata0 : own1 ? wdata1 : '0;
    release_now = ~gnt | (own0 ? last0 : last1) | (burst_cnt_q == CNT_W'(MAX_BURST - 1));
  end
  // Ownership FSM with burst counter and registered read-valid return
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 & ~we0;
      rvalid1_q <= gnt1 & ~we1;
      if (state_q == IDLE) begin
        burst_cnt_q <= '0;
        state_q     <= winner[0] ? OWN0 : winner[1] ? OWN1 : IDLE;
      end else if (release_now) begin
        state_q     <= IDLE;
        rr_ptr_q    <= own0;
        burst_cnt_q <= '0;
      end else begin
        burst_cnt_q <= burst_cnt_q + 1'b1;
      end
    end
  end
  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata   = mem_rdata;
  assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: directed vector table plus multi-cycle sequences against a behavioural bram
module tb_bram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, last0, last1;
  logic [11:0] addr0, addr1, mem_addr;
  logic [15:0] wdata0, wdata1, rdata, mem_wdata, mem_rdata;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy;
  logic [15:0] mem [0:4095];
  int          vecs = 0, errs = 0;
  always #5 clk = ~clk;
  bram_port_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .last0(last0), .last1(last1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  always @(posedge clk) begin
    if (rst) mem[12'h010] <= 16'hA5A5;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end
  typedef struct {
    logic rst, req0, we0, last0; logic [11:0] addr0; logic [15:0] wdata0;
    logic req1, we1, last1; logic [11:0] addr1; logic [15:0] wdata1;
    logic g0, g1, rv0, rv1, rd, wr, bsy; logic [11:0] maddr; logic chk; logic [15:0] rdat;
  } vec_t;
  vec_t tbl [20];
  function automatic logic [18:0] obs();
    return {gnt0, gnt1, rvalid0, rvalid1, mem_rd_en, mem_wr_en, busy, mem_addr};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_in();
    rst = 0; req0 = 0; we0 = 0; last0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; last1 = 0; addr1 = '0; wdata1 = '0;
  endtask
  int n1, nidle, wait_k;
  initial begin
    tbl[0]  = '{'0,'0,'0,'0,12'h000,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[1]  = '{'0,'1,'0,'1,12'h010,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[2]  = '{'0,'1,'0,'1,12'h010,16'h0000,'0,'0,'0,12'h000,16'h0000, '1,'0,'0,'0,'1,'0,'1,12'h010,'0,16'h0000};
    tbl[3]  = '{'0,'0,'0,'0,12'h000,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'1,'0,'0,'0,'0,12'h000,'1,16'hA5A5};
    tbl[4]  = '{'1,'0,'0,'0,12'h000,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[5]  = '{'0,'1,'1,'0,12'h020,16'h1111,'1,'1,'0,12'h37F,16'h1234, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[6]  = '{'0,'1,'1,'0,12'h021,16'h2222,'1,'1,'0,12'h37F,16'h1234, '1,'0,'0,'0,'0,'1,'1,12'h021,'0,16'h0000};
    tbl[7]  = '{'0,'1,'1,'1,12'h022,16'h3333,'1,'1,'0,12'h37F,16'h1234, '1,'0,'0,'0,'0,'1,'1,12'h022,'0,16'h0000};
    tbl[8]  = '{'0,'1,'0,'0,12'h010,16'h0000,'1,'1,'0,12'h37F,16'h1234, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[9]  = '{'0,'1,'0,'0,12'h010,16'h0000,'1,'1,'0,12'h37F,16'h1234, '0,'1,'0,'0,'0,'1,'1,12'h37F,'0,16'h0000};
    tbl[10] = '{'0,'1,'0,'0,12'h010,16'h0000,'1,'0,'1,12'h37F,16'h0000, '0,'1,'0,'0,'1,'0,'1,12'h37F,'0,16'h0000};
    tbl[11] = '{'0,'1,'0,'1,12'h010,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'1,'0,'0,'0,12'h000,'1,16'h1234};
    tbl[12] = '{'0,'1,'0,'1,12'h010,16'h0000,'0,'0,'0,12'h000,16'h0000, '1,'0,'0,'0,'1,'0,'1,12'h010,'0,16'h0000};
    tbl[13] = '{'0,'0,'0,'0,12'h000,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'1,'0,'0,'0,'0,12'h000,'1,16'hA5A5};
    tbl[14] = '{'0,'1,'0,'0,12'h022,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[15] = '{'0,'1,'0,'0,12'h022,16'h0000,'1,'0,'1,12'h021,16'h0000, '1,'0,'0,'0,'1,'0,'1,12'h022,'0,16'h0000};
    tbl[16] = '{'0,'0,'0,'0,12'h022,16'h0000,'1,'0,'1,12'h021,16'h0000, '0,'0,'1,'0,'0,'0,'1,12'h022,'1,16'h3333};
    tbl[17] = '{'0,'0,'0,'0,12'h000,16'h0000,'1,'0,'1,12'h021,16'h0000, '0,'0,'0,'0,'0,'0,'0,12'h000,'0,16'h0000};
    tbl[18] = '{'0,'0,'0,'0,12'h000,16'h0000,'1,'0,'1,12'h021,16'h0000, '0,'1,'0,'0,'1,'0,'1,12'h021,'0,16'h0000};
    tbl[19] = '{'0,'0,'0,'0,12'h000,16'h0000,'0,'0,'0,12'h000,16'h0000, '0,'0,'0,'1,'0,'0,'0,12'h000,'1,16'h2222};
    idle_in();
    rst = 1;
    cyc();
    cyc();
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst; req0 = tbl[i].req0; we0 = tbl[i].we0; last0 = tbl[i].last0;
      addr0 = tbl[i].addr0; wdata0 = tbl[i].wdata0;
      req1 = tbl[i].req1; we1 = tbl[i].we1; last1 = tbl[i].last1;
      addr1 = tbl[i].addr1; wdata1 = tbl[i].wdata1;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          64'({obs(), tbl[i].chk ? rdata : 16'h0000}),
          64'({tbl[i].g0, tbl[i].g1, tbl[i].rv0, tbl[i].rv1, tbl[i].rd, tbl[i].wr, tbl[i].bsy,
               tbl[i].maddr, tbl[i].chk ? tbl[i].rdat : 16'h0000}));
      cyc();
    end
    idle_in();
    req1 = 1; we1 = 1; addr1 = 12'h200; wdata1 = 16'hBEEF;
    cyc();
    req0 = 1; addr0 = 12'h010; last0 = 1;
    n1 = 0; nidle = 0; wait_k = 99;
    for (int k = 1; k <= 12 && wait_k == 99; k++) begin
      @(negedge clk);
      if (gnt1) n1++;
      if (!busy) nidle++;
      if (gnt0) wait_k = k;
      cyc();
    end
    chk("force_gnt1_count", 64'(n1), 64'd4);
    chk("force_idle_count", 64'(nidle), 64'd1);
    chk("force_gnt0_latency", 64'(wait_k), 64'd6);
    idle_in();
    req0 = 1; addr0 = 12'h010;
    cyc();
    rst = 1;
    @(negedge clk);
    chk("midburst_gnt0", 64'(gnt0), 64'd1);
    cyc();
    rst = 0; req1 = 1; addr1 = 12'h300;
    @(negedge clk);
    chk("post_reset_state", 64'(obs()), 64'd0);
    cyc();
    @(negedge clk);
    chk("rr_after_reset", 64'({gnt0, gnt1}), 64'd2);
    cyc();
    idle_in();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
